// File: rtl/calc_cmd_scheduler_pkg.sv
// Shared types and constants for the calculator command scheduler.
// Holds status encodings, command codes and the scheduler FSM state enum.
package calc_cmd_scheduler_pkg;

  localparam int unsigned CMD_W = 4;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    CS_ERROR = 2'b00,
    CS_BUSY  = 2'b01,
    CS_READY = 2'b10,
    CS_RSVD  = 2'b11
  } calc_status_e;

  // Digits 0-9 are passed through as their own value.
  localparam logic [CMD_W-1:0] OP_ADD = CMD_W'(10);
  localparam logic [CMD_W-1:0] OP_SUB = CMD_W'(11);
  localparam logic [CMD_W-1:0] OP_MUL = CMD_W'(12);
  localparam logic [CMD_W-1:0] OP_DIV = CMD_W'(13);
  localparam logic [CMD_W-1:0] EQUALS = CMD_W'(14);
  localparam logic [CMD_W-1:0] BKSP   = CMD_W'(15);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_ERROR
  } state_e;

  // Error and reserved encodings are both treated as a calculator fault.
  function automatic logic status_fault(input calc_status_e st);
    return (st == CS_ERROR) || (st == CS_RSVD);
  endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// Command FIFO for the scheduler: power-of-two depth, first-word fall-through head.
// Flush wins over push/pop; level_nxt_o exposes the occupancy after this edge.
module calc_cmd_fifo
  import calc_cmd_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [CMD_W-1:0] wdata_i,
  output logic [CMD_W-1:0] head_o,
  output logic [LVL_W-1:0] level_o,
  output logic [LVL_W-1:0] level_nxt_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is 2^PTR_W.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o      = mem_q[rd_ptr_q];
  assign level_o     = level_q;
  assign level_nxt_o = level_d;

endmodule

// File: rtl/calc_cmd_scheduler.sv
// Buffers calculator commands and hands them one at a time to the calculator,
// following its ready/busy handshake with a stuck-ready timeout and sticky error.
module calc_cmd_scheduler
  import calc_cmd_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 1023,
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  input  logic [3:0]       in_cmd_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  input  logic [1:0]       calc_status_i,
  output logic [3:0]       cmd_o,
  output logic             cmd_valid_o,
  output logic [LVL_W-1:0] level_o,
  output logic [7:0]       issued_cnt_o,
  output logic             err_o,
  output logic             idle_o
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               in_ready_q, in_ready_d;
  logic               idle_q, idle_d;

  calc_status_e       status;
  logic               fault;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_flush;
  logic [CMD_W-1:0]   fifo_head;
  logic [LVL_W-1:0]   fifo_level;
  logic [LVL_W-1:0]   fifo_level_nxt;
  logic               fifo_full;
  logic               fifo_empty;

  assign status    = calc_status_e'(calc_status_i);
  assign fault     = status_fault(status);
  assign fifo_push = in_valid_i && in_ready_q && !fifo_full;

  calc_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .pop_i       (fifo_pop),
    .flush_i     (fifo_flush),
    .wdata_i     (in_cmd_i),
    .head_o      (fifo_head),
    .level_o     (fifo_level),
    .level_nxt_o (fifo_level_nxt),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Next-state and registered-output logic for the issue handshake.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    tmo_d       = tmo_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty && fault) begin
          state_d = S_ERROR;
        end else if (flush_i) begin
          fifo_flush = 1'b1;
        end else if (!fifo_empty && (status == CS_READY)) begin
          state_d     = S_ISSUE;
          cmd_d       = fifo_head;
          cmd_valid_d = 1'b1;
          tmo_d       = '0;
        end
      end
      S_ISSUE: begin
        if (fault) begin
          state_d = S_ERROR;
        end else if (status == CS_BUSY) begin
          state_d     = S_WAIT_DONE;
          fifo_pop    = 1'b1;
          cmd_d       = '0;
          cmd_valid_d = 1'b0;
          tmo_d       = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_d == TMO_W'(TIMEOUT)) state_d = S_ERROR;
        end
      end
      S_WAIT_DONE: begin
        if (fault) begin
          state_d = S_ERROR;
        end else if (status == CS_READY) begin
          state_d = S_IDLE;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase

    // Entering or sitting in ERROR drops the command and keeps the FIFO empty.
    if (state_d == S_ERROR) begin
      err_d       = 1'b1;
      cmd_d       = '0;
      cmd_valid_d = 1'b0;
      tmo_d       = '0;
      fifo_flush  = 1'b1;
    end
  end

  assign in_ready_d = (state_d != S_ERROR) && (fifo_level_nxt != LVL_W'(DEPTH));
  assign idle_d     = (state_d == S_IDLE) && (fifo_level_nxt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      tmo_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      tmo_q       <= tmo_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      idle_q      <= idle_d;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign cmd_o        = cmd_q;
  assign cmd_valid_o  = cmd_valid_q;
  assign level_o      = fifo_level;
  assign issued_cnt_o = cnt_q;
  assign err_o        = err_q;
  assign idle_o       = idle_q;

endmodule

// File: tb/tb_calc_cmd_scheduler.sv
// Directed self-checking bench for calc_cmd_scheduler (DEPTH=8, TIMEOUT=1023).
module tb_calc_cmd_scheduler;
  import calc_cmd_scheduler_pkg::*;

  localparam int TMO = 1023;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_cmd = 4'd0;
  logic       flush = 1'b0;
  logic [1:0] calc_status = 2'b01;
  logic       in_ready;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic [3:0] level;
  logic [7:0] issued_cnt;
  logic       err;
  logic       idle;

  int n_cmp = 0;
  int n_fail = 0;

  calc_cmd_scheduler #(
    .DEPTH   (8),
    .TIMEOUT (1023)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (in_valid),
    .in_cmd_i      (in_cmd),
    .in_ready_o    (in_ready),
    .flush_i       (flush),
    .calc_status_i (calc_status),
    .cmd_o         (cmd),
    .cmd_valid_o   (cmd_valid),
    .level_o       (level),
    .issued_cnt_o  (issued_cnt),
    .err_o         (err),
    .idle_o        (idle)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] st);
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; in_cmd = 4'd0; calc_status = st;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push(input logic [3:0] v);
    in_valid = 1'b1; in_cmd = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (cmd_valid !== 1'b1 && cycles < 64) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; calc_status = CS_READY; in_valid = 1'b0; flush = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, cmd_valid, err, cmd, level, issued_cnt} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b vld=%b err=%b cmd=%0d lvl=%0d cnt=%0d want all 0",
               in_ready, cmd_valid, err, cmd, level, issued_cnt);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({in_ready, idle} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b idle=%b want 1 1", in_ready, idle);
    end
    calc_status = CS_ERROR;
    repeat (3) tick();
    calc_status = CS_RSVD;
    tick();
    n_cmp++;
    if ({err, idle} !== 2'b01) begin
      n_fail++;
      $display("FAIL idle_fault_empty: got err=%b idle=%b want 0 1", err, idle);
    end
    push(4'd7);
    n_cmp++;
    if ({err, level} !== {1'b0, 4'd1}) begin
      n_fail++;
      $display("FAIL idle_fault_push: got err=%b lvl=%0d want 0 1", err, level);
    end
    tick();
    n_cmp++;
    if ({err, level, in_ready} !== {1'b1, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL idle_fault_nonempty: got err=%b lvl=%0d rdy=%b want 1 0 0", err, level, in_ready);
    end
  endtask

  task automatic test_sequence();
    logic [3:0] exp [5];
    int c;
    exp[0] = 4'd1; exp[1] = 4'd2; exp[2] = OP_ADD; exp[3] = 4'd3; exp[4] = EQUALS;
    do_reset(CS_BUSY);
    for (int i = 0; i < 5; i++) push(exp[i]);
    n_cmp++;
    if ({level, cmd_valid} !== {4'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL seq_loaded: got lvl=%0d vld=%b want 5 0", level, cmd_valid);
    end
    calc_status = CS_READY;
    for (int i = 0; i < 5; i++) begin
      wait_valid(c);
      n_cmp++;
      if ({cmd_valid, cmd} !== {1'b1, exp[i]}) begin
        n_fail++;
        $display("FAIL seq_cmd%0d: got vld=%b cmd=%0d want 1 %0d", i, cmd_valid, cmd, exp[i]);
      end
      calc_status = CS_BUSY;
      tick();
      n_cmp++;
      if ({cmd_valid, cmd} !== 5'd0) begin
        n_fail++;
        $display("FAIL seq_wait%0d: got vld=%b cmd=%0d want 0 0", i, cmd_valid, cmd);
      end
      tick();
      calc_status = CS_READY;
    end
    repeat (2) tick();
    n_cmp++;
    if ({issued_cnt, idle, level, err} !== {8'd5, 1'b1, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL seq_done: got cnt=%0d idle=%b lvl=%0d err=%b want 5 1 0 0", issued_cnt, idle, level, err);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp [3];
    int c;
    exp[0] = 4'd4; exp[1] = 4'd5; exp[2] = 4'd6;
    do_reset(CS_BUSY);
    for (int i = 0; i < 3; i++) push(exp[i]);
    calc_status = CS_READY;
    wait_valid(c);
    n_cmp++;
    if (cmd !== exp[0]) begin
      n_fail++;
      $display("FAIL b2b_first: got cmd=%0d want %0d", cmd, exp[0]);
    end
    for (int i = 1; i < 3; i++) begin
      calc_status = CS_BUSY;
      tick();
      calc_status = CS_READY;
      wait_valid(c);
      n_cmp++;
      if ({cmd_valid, cmd} !== {1'b1, exp[i]} || (c + 1) != 3) begin
        n_fail++;
        $display("FAIL b2b_spacing%0d: got vld=%b cmd=%0d gap=%0d want 1 %0d 3", i, cmd_valid, cmd, c + 1, exp[i]);
      end
    end
    calc_status = CS_BUSY;
    tick();
    calc_status = CS_READY;
    repeat (2) tick();
    n_cmp++;
    if (issued_cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 3", issued_cnt);
    end
  endtask

  task automatic test_full();
    int c;
    do_reset(CS_BUSY);
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_cmd = 4'(i + 1);
      if (i == 8) begin
        n_cmp++;
        if ({in_ready, level} !== {1'b0, 4'd8}) begin
          n_fail++;
          $display("FAIL full_ready: got rdy=%b lvl=%0d want 0 8", in_ready, level);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (level !== 4'd8) begin
      n_fail++;
      $display("FAIL full_reject: got lvl=%0d want 8", level);
    end
    calc_status = CS_READY;
    wait_valid(c);
    n_cmp++;
    if ({cmd_valid, cmd} !== {1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL full_head: got vld=%b cmd=%0d want 1 1", cmd_valid, cmd);
    end
  endtask

  task automatic test_push_pop();
    int c;
    do_reset(CS_BUSY);
    push(OP_SUB);
    push(4'd2);
    calc_status = CS_READY;
    wait_valid(c);
    n_cmp++;
    if (cmd !== OP_SUB) begin
      n_fail++;
      $display("FAIL pp_first: got cmd=%0d want %0d", cmd, OP_SUB);
    end
    calc_status = CS_BUSY;
    in_valid = 1'b1; in_cmd = OP_MUL;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (level !== 4'd2) begin
      n_fail++;
      $display("FAIL pp_level: got lvl=%0d want 2", level);
    end
    tick();
    calc_status = CS_READY;
    wait_valid(c);
    n_cmp++;
    if ({cmd_valid, cmd} !== {1'b1, 4'd2}) begin
      n_fail++;
      $display("FAIL pp_second: got vld=%b cmd=%0d want 1 2", cmd_valid, cmd);
    end
    calc_status = CS_BUSY;
    tick();
    calc_status = CS_READY;
    wait_valid(c);
    n_cmp++;
    if ({cmd_valid, cmd} !== {1'b1, OP_MUL}) begin
      n_fail++;
      $display("FAIL pp_third: got vld=%b cmd=%0d want 1 %0d", cmd_valid, cmd, OP_MUL);
    end
  endtask

  task automatic test_flush();
    int c;
    do_reset(CS_BUSY);
    for (int i = 0; i < 4; i++) push(4'(i + 1));
    n_cmp++;
    if (level !== 4'd4) begin
      n_fail++;
      $display("FAIL flush_load: got lvl=%0d want 4", level);
    end
    flush = 1'b1; in_valid = 1'b1; in_cmd = 4'd9;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if ({level, idle} !== {4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_idle: got lvl=%0d idle=%b want 0 1", level, idle);
    end
    push(4'd3);
    push(4'd8);
    calc_status = CS_READY;
    wait_valid(c);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++;
    if ({level, cmd_valid, cmd} !== {4'd2, 1'b1, 4'd3}) begin
      n_fail++;
      $display("FAIL flush_ignored: got lvl=%0d vld=%b cmd=%0d want 2 1 3", level, cmd_valid, cmd);
    end
  endtask

  task automatic test_timeout();
    int c;
    int changes;
    do_reset(CS_BUSY);
    push(4'd5);
    push(4'd6);
    calc_status = CS_READY;
    tick();
    n_cmp++;
    if ({cmd_valid, cmd} !== {1'b1, 4'd5}) begin
      n_fail++;
      $display("FAIL tmo_entry: got vld=%b cmd=%0d want 1 5", cmd_valid, cmd);
    end
    c = 0;
    changes = 0;
    while (err !== 1'b1 && c < TMO + 50) begin
      tick();
      c++;
      if (err !== 1'b1 && cmd !== 4'd5) changes++;
    end
    n_cmp++;
    if (c != TMO) begin
      n_fail++;
      $display("FAIL tmo_cycles: got %0d want %0d", c, TMO);
    end
    n_cmp++;
    if (changes != 0) begin
      n_fail++;
      $display("FAIL tmo_cmd_stable: got %0d changes want 0", changes);
    end
    n_cmp++;
    if ({level, cmd_valid, cmd, in_ready} !== 10'd0) begin
      n_fail++;
      $display("FAIL tmo_error_state: got lvl=%0d vld=%b cmd=%0d rdy=%b want 0 0 0 0", level, cmd_valid, cmd, in_ready);
    end
    push(4'd1);
    tick();
    n_cmp++;
    if ({err, level} !== {1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL tmo_sticky: got err=%b lvl=%0d want 1 0", err, level);
    end
  endtask

  task automatic test_wait_error();
    int c;
    do_reset(CS_BUSY);
    push(4'd2);
    calc_status = CS_READY;
    wait_valid(c);
    calc_status = CS_BUSY;
    tick();
    calc_status = CS_ERROR;
    tick();
    n_cmp++;
    if ({err, cmd_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL werr_enter: got err=%b vld=%b want 1 0", err, cmd_valid);
    end
    calc_status = CS_READY;
    repeat (5) tick();
    n_cmp++;
    if ({err, idle, issued_cnt, in_ready} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL werr_sticky: got err=%b idle=%b cnt=%0d rdy=%b want 1 0 0 0", err, idle, issued_cnt, in_ready);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL werr_reset: got err=%b want 0", err);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_issue();
    int c;
    do_reset(CS_BUSY);
    push(4'd1);
    push(4'd2);
    calc_status = CS_READY;
    wait_valid(c);
    calc_status = CS_BUSY;
    tick();
    calc_status = CS_READY;
    wait_valid(c);
    n_cmp++;
    if ({issued_cnt, cmd} !== {8'd1, 4'd2}) begin
      n_fail++;
      $display("FAIL mid_pre: got cnt=%0d cmd=%0d want 1 2", issued_cnt, cmd);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_valid, cmd, issued_cnt, level, err, in_ready} !== 19'd0) begin
      n_fail++;
      $display("FAIL mid_async: got vld=%b cmd=%0d cnt=%0d lvl=%0d err=%b rdy=%b want all 0",
               cmd_valid, cmd, issued_cnt, level, err, in_ready);
    end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({issued_cnt, cmd_valid, idle} !== {8'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_after: got cnt=%0d vld=%b idle=%b want 0 0 1", issued_cnt, cmd_valid, idle);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_back_to_back();
    test_full();
    test_push_pop();
    test_flush();
    test_timeout();
    test_wait_error();
    test_reset_mid_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/calc_cmd_scheduler.md
CALC_CMD_SCHEDULER -- requirements
Module: calc_cmd_scheduler

Interface
REQ-001 Parameter DEPTH, 8, command FIFO entries; power of two, range 2..16.
REQ-002 Parameter TIMEOUT, 1023, max cycles calc may stay ready after issue before error.
REQ-003 clock  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  producer offers in_cmd this cycle.
REQ-006 in_cmd  input  4  calculator command code (0-9 digit, 10-13 op, 14 equals, 15 backspace).
REQ-007 in_ready  output  1  FIFO can accept; push occurs when in_valid and in_ready both high.
REQ-008 flush  input  1  synchronous FIFO clear, honoured only in IDLE.
REQ-009 calc_status  input  2  calculator status: 00 error, 01 busy, 10 ready, 11 reserved.
REQ-010 cmd  output  4  command presented to calculator.
REQ-011 cmd_valid  output  1  cmd is meaningful; calculator acts on cmd only while high.
REQ-012 level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 issued_cnt  output  8  commands completed since reset, wraps 255->0.
REQ-014 err  output  1  sticky error flag.
REQ-015 idle  output  1  high in IDLE with empty FIFO.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_DONE, ERROR.
REQ-017 in_ready SHALL equal not-full; no bypass; full FIFO ignores pushes, no overwrite.
REQ-018 Push and pop in same cycle SHALL leave level unchanged and preserve order.
REQ-019 IDLE: if FIFO non-empty and calc_status==10, go to ISSUE next cycle; else stay.
REQ-020 ISSUE: cmd=FIFO head, cmd_valid=1, held stable; timeout counter increments each cycle.
REQ-021 ISSUE: calc_status==01 -> pop head, cmd_valid=0 next cycle, clear timeout counter, go WAIT_DONE.
REQ-022 ISSUE: timeout counter reaching TIMEOUT with status still 10 -> ERROR.
REQ-023 WAIT_DONE: cmd_valid=0; calc_status==10 -> increment issued_cnt, go IDLE.
REQ-024 Any non-IDLE/non-ERROR state: calc_status==00 or 11 -> ERROR, taking priority over other transitions same cycle.
REQ-025 IDLE: calc_status==00 or 11 with FIFO non-empty -> ERROR; with FIFO empty stay IDLE, no error.
REQ-026 ERROR: err=1, cmd_valid=0, FIFO cleared, in_ready=0; exit only by reset.
REQ-027 flush in IDLE SHALL empty FIFO next cycle, overriding a same-cycle push; ignored elsewhere.
REQ-028 Minimum issue-to-issue spacing SHALL be 3 cycles (ISSUE, WAIT_DONE, IDLE).
REQ-029 cmd SHALL be 0 whenever cmd_valid is 0.

Reset
REQ-030 Reset asserted: state IDLE, FIFO empty, level 0, cmd 0, cmd_valid 0, issued_cnt 0, err 0, timeout counter 0.
REQ-031 in_ready SHALL be 0 during reset and 1 the first cycle after release; idle 1 after release.
REQ-032 Reset mid-ISSUE SHALL drop the in-flight command; it is never counted.

Structure
REQ-033 Shared package SHALL hold calc_status encodings, command code constants (OP_ADD=10, OP_SUB=11, OP_MUL=12, EQUALS=14, BKSP=15) and the FSM state enum.
REQ-034 FIFO SHALL be a separate sub-module calc_cmd_fifo (DEPTH, 4-bit data, push/pop/flush/level/full/empty).

Verification
REQ-035 Push 1,2,10,3,14 with calc model busy 2 cycles per command -> cmd sequence 1,2,10,3,14 in order, issued_cnt=5, idle=1.
REQ-036 Push 9 entries with status held 01 (DEPTH=8) -> in_ready=0 at level 8, ninth rejected, level stays 8.
REQ-037 Issue with model never leaving 10 -> err=1 exactly TIMEOUT cycles after ISSUE entry, FIFO cleared.
REQ-038 Model drives 00 during WAIT_DONE -> ERROR next cycle, cmd_valid=0, err stays 1 until reset.
REQ-039 Load 4 entries, status 01, assert flush with simultaneous push in IDLE -> level 0 next cycle.
REQ-040 Reset asserted during ISSUE -> all outputs at reset values asynchronously, issued_cnt 0.
